// File: rtl/sc_pointctrl_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sc_pointctrl_fsm                                             |
// | Description : Player-car lateral controller. Turns the start/left/right   |
// |               buttons and the bottom-side collision comparator into the   |
// |               shift/clear/load strobes of the player-car register, tracks |
// |               the lane index, auto-repeats held moves and freezes the car |
// |               for a timed crash window followed by a reload.              |
// | Option      : SC_POINTCTRL_WRAP_EN - when defined, moves past a road edge |
// |               wrap around to the other edge instead of saturating.        |
// | Ports       : SC_POINTCTRL_CLOCK_50      clock, rising edge               |
// |               SC_POINTCTRL_RESET_InHigh  synchronous reset, active-high    |
// |               *_startButton/leftButton/rightButton_InLow  buttons (low)   |
// |               *_bottomsidecomparator_InLow  collision detect (low)        |
// |               *_clear_OutLow / *_load0_OutLow  1-cycle low strobes        |
// |               *_load1_OutLow             reserved, constant 1             |
// |               *_shiftselection_Out       01 left, 10 right, 11 hold       |
// |               *_position_Out             current lane index               |
// |               *_crash_Out                high while frozen after a crash  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sc_pointctrl_fsm #(
  parameter int NUM_POS       = 8,
  parameter int START_POS     = 3,
  parameter int HOLD_DELAY    = 12_500_000,
  parameter int REPEAT_PERIOD = 5_000_000,
  parameter int CRASH_CYCLES  = 50_000_000
) (
  input  logic                       SC_POINTCTRL_CLOCK_50,
  input  logic                       SC_POINTCTRL_RESET_InHigh,
  input  logic                       SC_POINTCTRL_startButton_InLow,
  input  logic                       SC_POINTCTRL_leftButton_InLow,
  input  logic                       SC_POINTCTRL_rightButton_InLow,
  input  logic                       SC_POINTCTRL_bottomsidecomparator_InLow,
  output logic                       SC_POINTCTRL_clear_OutLow,
  output logic                       SC_POINTCTRL_load0_OutLow,
  output logic                       SC_POINTCTRL_load1_OutLow,
  output logic [1:0]                 SC_POINTCTRL_shiftselection_Out,
  output logic [$clog2(NUM_POS)-1:0] SC_POINTCTRL_position_Out,
  output logic                       SC_POINTCTRL_crash_Out
);

  localparam int POS_W   = $clog2(NUM_POS);
  localparam int MAX_A   = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
  localparam int MAX_CNT = (MAX_A > CRASH_CYCLES) ? MAX_A : CRASH_CYCLES;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  localparam logic [POS_W-1:0] POS_START  = POS_W'(START_POS);
  localparam logic [POS_W-1:0] POS_LAST   = POS_W'(NUM_POS - 1);
  localparam logic [POS_W-1:0] POS_ONE    = POS_W'(1);
  localparam logic [CNT_W-1:0] CNT_HOLD   = CNT_W'(HOLD_DELAY - 1);
  localparam logic [CNT_W-1:0] CNT_REPEAT = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_CRASH  = CNT_W'(CRASH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  localparam logic [1:0] SHIFT_LEFT  = 2'b01;
  localparam logic [1:0] SHIFT_RIGHT = 2'b10;
  localparam logic [1:0] SHIFT_HOLD  = 2'b11;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [3:0] {
    ST_RESET   = 4'd0,
    ST_START   = 4'd1,
    ST_CHECK   = 4'd2,
    ST_INIT    = 4'd3,
    ST_LEFT    = 4'd4,
    ST_RIGHT   = 4'd5,
    ST_HOLD    = 4'd6,
    ST_RELEASE = 4'd7,
    ST_CRASH   = 4'd8,
    ST_RECOVER = 4'd9
  } state_t;

  state_t           state;
  logic [POS_W-1:0] pos;
  logic [CNT_W-1:0] cnt;
  logic             dir;
  logic             clear_n;
  logic             load0_n;
  logic [1:0]       shift_sel;
  logic             crash;

  // Active-high views of the active-low inputs.
  logic collide;
  logic start_pressed;
  logic left_pressed;
  logic right_pressed;
  logic dir_pressed;

  assign collide       = ~SC_POINTCTRL_bottomsidecomparator_InLow;
  assign start_pressed = ~SC_POINTCTRL_startButton_InLow;
  assign left_pressed  = ~SC_POINTCTRL_leftButton_InLow;
  assign right_pressed = ~SC_POINTCTRL_rightButton_InLow;
  assign dir_pressed   = (dir == DIR_LEFT) ? left_pressed : right_pressed;

  // Target lane and strobe for a move in each direction. At the edge the
  // car either stays put with no strobe, or wraps and the downstream
  // register rotates with the same strobe as a normal move.
  logic [POS_W-1:0] pos_left;
  logic [POS_W-1:0] pos_right;
  logic [1:0]       shift_left;
  logic [1:0]       shift_right;

`ifdef SC_POINTCTRL_WRAP_EN
  assign pos_left    = (pos == '0) ? POS_LAST : (pos - POS_ONE);
  assign pos_right   = (pos == POS_LAST) ? '0 : (pos + POS_ONE);
  assign shift_left  = SHIFT_LEFT;
  assign shift_right = SHIFT_RIGHT;
`else
  assign pos_left    = (pos == '0) ? pos : (pos - POS_ONE);
  assign pos_right   = (pos == POS_LAST) ? pos : (pos + POS_ONE);
  assign shift_left  = (pos == '0) ? SHIFT_HOLD : SHIFT_LEFT;
  assign shift_right = (pos == POS_LAST) ? SHIFT_HOLD : SHIFT_RIGHT;
`endif

  // Outputs are registered alongside the state: each branch sets the
  // strobe values belonging to the state being entered, and the idle
  // values written first cover every state without a strobe. The lane and
  // the counter are loaded on the same edge that enters the move state, so
  // the move state itself already counts down one cycle of the delay.
  always_ff @(posedge SC_POINTCTRL_CLOCK_50) begin
    if (SC_POINTCTRL_RESET_InHigh) begin
      state     <= ST_RESET;
      pos       <= POS_START;
      cnt       <= '0;
      dir       <= DIR_LEFT;
      clear_n   <= 1'b1;
      load0_n   <= 1'b1;
      shift_sel <= SHIFT_HOLD;
      crash     <= 1'b0;
    end else begin
      clear_n   <= 1'b1;
      load0_n   <= 1'b1;
      shift_sel <= SHIFT_HOLD;
      crash     <= 1'b0;
      case (state)
        ST_RESET: state <= ST_START;
        ST_START: state <= ST_CHECK;
        ST_CHECK: begin
          if (collide) begin
            state <= ST_CRASH;
            cnt   <= CNT_CRASH;
            crash <= 1'b1;
          end else if (start_pressed) begin
            state   <= ST_INIT;
            pos     <= POS_START;
            clear_n <= 1'b0;
          end else if (left_pressed && !right_pressed) begin
            state     <= ST_LEFT;
            dir       <= DIR_LEFT;
            pos       <= pos_left;
            shift_sel <= shift_left;
            cnt       <= CNT_HOLD;
          end else if (right_pressed && !left_pressed) begin
            state     <= ST_RIGHT;
            dir       <= DIR_RIGHT;
            pos       <= pos_right;
            shift_sel <= shift_right;
            cnt       <= CNT_HOLD;
          end
        end
        ST_INIT: state <= ST_RELEASE;
        ST_LEFT, ST_RIGHT: begin
          state <= ST_HOLD;
          // Guard keeps a one-cycle delay from underflowing the counter.
          if (cnt != '0) cnt <= cnt - CNT_ONE;
        end
        ST_HOLD: begin
          if (collide) begin
            state <= ST_CRASH;
            cnt   <= CNT_CRASH;
            crash <= 1'b1;
          end else if (!dir_pressed) begin
            state <= ST_CHECK;
          end else if (cnt == '0) begin
            cnt <= CNT_REPEAT;
            if (dir == DIR_LEFT) begin
              state     <= ST_LEFT;
              pos       <= pos_left;
              shift_sel <= shift_left;
            end else begin
              state     <= ST_RIGHT;
              pos       <= pos_right;
              shift_sel <= shift_right;
            end
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        ST_RELEASE: begin
          if (collide) begin
            state <= ST_CRASH;
            cnt   <= CNT_CRASH;
            crash <= 1'b1;
          end else if (!start_pressed && !left_pressed && !right_pressed) begin
            state <= ST_CHECK;
          end
        end
        ST_CRASH: begin
          if (cnt == '0) begin
            state   <= ST_RECOVER;
            pos     <= POS_START;
            load0_n <= 1'b0;
          end else begin
            cnt   <= cnt - CNT_ONE;
            crash <= 1'b1;
          end
        end
        // Recovery always passes through RELEASE so a button still held
        // from before the crash cannot move the car.
        ST_RECOVER: state <= ST_RELEASE;
        default:    state <= ST_CHECK;
      endcase
    end
  end

  assign SC_POINTCTRL_clear_OutLow       = clear_n;
  assign SC_POINTCTRL_load0_OutLow       = load0_n;
  assign SC_POINTCTRL_load1_OutLow       = 1'b1;
  assign SC_POINTCTRL_shiftselection_Out = shift_sel;
  assign SC_POINTCTRL_position_Out       = pos;
  assign SC_POINTCTRL_crash_Out          = crash;

endmodule
`default_nettype wire

// File: tb/tb_sc_pointctrl_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sc_pointctrl_fsm                                          |
// | Description : Self-checking bench for sc_pointctrl_fsm with short timing  |
// |               parameters: directed vector table, multi-cycle sequences    |
// |               and randomized stimulus against a timestamp-based model.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_sc_pointctrl_fsm;

  localparam int NUM_POS       = 8;
  localparam int START_POS     = 3;
  localparam int HOLD_DELAY    = 4;
  localparam int REPEAT_PERIOD = 2;
  localparam int CRASH_CYCLES  = 6;
  localparam int POS_W         = $clog2(NUM_POS);

`ifdef SC_POINTCTRL_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start_n = 1'b1;
  logic             left_n = 1'b1;
  logic             right_n = 1'b1;
  logic             coll_n = 1'b1;
  logic             clear_n;
  logic             load0_n;
  logic             load1_n;
  logic [1:0]       shift_sel;
  logic [POS_W-1:0] pos;
  logic             crash;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sc_pointctrl_fsm #(
    .NUM_POS       (NUM_POS),
    .START_POS     (START_POS),
    .HOLD_DELAY    (HOLD_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD),
    .CRASH_CYCLES  (CRASH_CYCLES)
  ) dut (
    .SC_POINTCTRL_CLOCK_50                   (clk),
    .SC_POINTCTRL_RESET_InHigh               (rst),
    .SC_POINTCTRL_startButton_InLow          (start_n),
    .SC_POINTCTRL_leftButton_InLow           (left_n),
    .SC_POINTCTRL_rightButton_InLow          (right_n),
    .SC_POINTCTRL_bottomsidecomparator_InLow (coll_n),
    .SC_POINTCTRL_clear_OutLow               (clear_n),
    .SC_POINTCTRL_load0_OutLow               (load0_n),
    .SC_POINTCTRL_load1_OutLow               (load1_n),
    .SC_POINTCTRL_shiftselection_Out         (shift_sel),
    .SC_POINTCTRL_position_Out               (pos),
    .SC_POINTCTRL_crash_Out                  (crash)
  );

  // ---------------------------------------------------------------------
  // Reference model: tracks what the car is doing in behavioural terms and
  // uses absolute edge numbers as deadlines for repeats and crash recovery.
  // ---------------------------------------------------------------------
  typedef enum int {M_BOOT1, M_BOOT2, M_IDLE, M_CLEAR, M_MOVE, M_HELD,
                    M_WAIT, M_CRASH, M_RECOVER} mphase_e;

  mphase_e    m_phase = M_BOOT1;
  int         m_pos = START_POS;
  int         m_dir = -1;
  longint     m_edge = 0;
  longint     m_move_due = 0;
  longint     m_crash_end = 0;
  int         e_pos = START_POS;
  logic [1:0] e_shift = 2'b11;
  logic       e_clear = 1'b1;
  logic       e_load0 = 1'b1;
  logic       e_crash = 1'b0;

  task automatic model_crash();
    m_phase     = M_CRASH;
    m_crash_end = m_edge + CRASH_CYCLES;
    e_crash     = 1'b1;
  endtask

  task automatic model_move(input int d, input int delay);
    int t;
    t = m_pos + d;
    if (t >= 0 && t < NUM_POS) begin
      m_pos   = t;
      e_shift = (d < 0) ? 2'b01 : 2'b10;
    end else if (WRAP) begin
      m_pos   = (t + NUM_POS) % NUM_POS;
      e_shift = (d < 0) ? 2'b01 : 2'b10;
    end
    m_dir      = d;
    m_phase    = M_MOVE;
    // The move cycle itself takes one cycle, so two is the shortest gap.
    m_move_due = m_edge + ((delay < 2) ? 2 : delay);
  endtask

  // Predicts the outputs after the coming clock edge from the inputs that
  // will be sampled on it.
  task automatic model_step();
    bit p_start, p_left, p_right, p_coll, p_dir;
    p_start = !start_n;
    p_left  = !left_n;
    p_right = !right_n;
    p_coll  = !coll_n;
    m_edge++;
    e_shift = 2'b11;
    e_clear = 1'b1;
    e_load0 = 1'b1;
    e_crash = 1'b0;
    if (rst) begin
      m_phase = M_BOOT1;
      m_pos   = START_POS;
    end else begin
      case (m_phase)
        M_BOOT1: m_phase = M_BOOT2;
        M_BOOT2: m_phase = M_IDLE;
        M_IDLE: begin
          if (p_coll) model_crash();
          else if (p_start) begin
            m_phase = M_CLEAR;
            m_pos   = START_POS;
            e_clear = 1'b0;
          end
          else if (p_left && !p_right) model_move(-1, HOLD_DELAY);
          else if (p_right && !p_left) model_move(1, HOLD_DELAY);
        end
        M_CLEAR: m_phase = M_WAIT;
        M_MOVE:  m_phase = M_HELD;
        M_HELD: begin
          p_dir = (m_dir < 0) ? p_left : p_right;
          if (p_coll) model_crash();
          else if (!p_dir) m_phase = M_IDLE;
          else if (m_edge == m_move_due) model_move(m_dir, REPEAT_PERIOD);
        end
        M_WAIT: begin
          if (p_coll) model_crash();
          else if (!p_start && !p_left && !p_right) m_phase = M_IDLE;
        end
        M_CRASH: begin
          if (m_edge == m_crash_end) begin
            m_phase = M_RECOVER;
            m_pos   = START_POS;
            e_load0 = 1'b0;
          end else begin
            e_crash = 1'b1;
          end
        end
        default: m_phase = M_WAIT;
      endcase
    end
    e_pos = m_pos;
  endtask

  // Drive one cycle: inputs set at the falling edge, model advanced, then
  // wait through the rising edge to the next falling edge for sampling.
  task automatic tick(input bit r, input bit s, input bit l, input bit rt, input bit c);
    rst     = r;
    start_n = s;
    left_n  = l;
    right_n = rt;
    coll_n  = c;
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input int x_pos, input logic [1:0] x_shift,
                       input logic x_clear, input logic x_load0, input logic x_crash);
    checks++;
    if (int'(pos) != x_pos || shift_sel !== x_shift || clear_n !== x_clear ||
        load0_n !== x_load0 || load1_n !== 1'b1 || crash !== x_crash) begin
      errors++;
      $display("FAIL %s: got pos=%0d shift=%b clr=%b ld0=%b ld1=%b crash=%b, expected pos=%0d shift=%b clr=%b ld0=%b ld1=1 crash=%b",
               name, pos, shift_sel, clear_n, load0_n, load1_n, crash,
               x_pos, x_shift, x_clear, x_load0, x_crash);
    end
  endtask

  typedef struct {
    bit         rst;
    bit         start_n;
    bit         left_n;
    bit         right_n;
    bit         coll_n;
    int         pos;
    logic [1:0] shift;
    bit         clear_n;
    bit         load0_n;
    bit         crash;
  } vec_t;

  vec_t tbl[21];

  initial begin
    int exp_pos;
    logic [1:0] exp_sh;
    bit mv;

    // rst start left right coll | pos shift clear load0 crash
    tbl[0]  = '{1, 1, 1, 1, 1, 3, 2'd3, 1, 1, 0};  // reset held
    tbl[1]  = '{1, 1, 1, 1, 1, 3, 2'd3, 1, 1, 0};
    tbl[2]  = '{1, 1, 1, 1, 1, 3, 2'd3, 1, 1, 0};
    tbl[3]  = '{0, 1, 1, 1, 1, 3, 2'd3, 1, 1, 0};  // START
    tbl[4]  = '{0, 1, 1, 1, 1, 3, 2'd3, 1, 1, 0};  // CHECK
    tbl[5]  = '{0, 1, 0, 1, 1, 2, 2'd1, 1, 1, 0};  // left tap -> one pulse
    tbl[6]  = '{0, 1, 1, 1, 1, 2, 2'd3, 1, 1, 0};
    tbl[7]  = '{0, 1, 1, 1, 1, 2, 2'd3, 1, 1, 0};
    tbl[8]  = '{0, 1, 1, 1, 1, 2, 2'd3, 1, 1, 0};
    tbl[9]  = '{0, 1, 0, 0, 1, 2, 2'd3, 1, 1, 0};  // both low -> no move
    tbl[10] = '{0, 1, 0, 0, 1, 2, 2'd3, 1, 1, 0};
    tbl[11] = '{0, 0, 1, 1, 1, 3, 2'd3, 0, 1, 0};  // start -> clear pulse
    tbl[12] = '{0, 0, 1, 1, 1, 3, 2'd3, 1, 1, 0};  // held start waits
    tbl[13] = '{0, 1, 1, 1, 1, 3, 2'd3, 1, 1, 0};
    tbl[14] = '{0, 1, 1, 1, 1, 3, 2'd3, 1, 1, 0};
    tbl[15] = '{0, 1, 1, 0, 1, 4, 2'd2, 1, 1, 0};  // right tap
    tbl[16] = '{0, 1, 1, 1, 1, 4, 2'd3, 1, 1, 0};
    tbl[17] = '{0, 1, 1, 1, 1, 4, 2'd3, 1, 1, 0};
    tbl[18] = '{0, 1, 0, 1, 1, 3, 2'd1, 1, 1, 0};  // left tap
    tbl[19] = '{0, 1, 1, 1, 1, 3, 2'd3, 1, 1, 0};
    tbl[20] = '{0, 1, 1, 1, 1, 3, 2'd3, 1, 1, 0};

    for (int i = 0; i < 21; i++) begin
      tick(tbl[i].rst, tbl[i].start_n, tbl[i].left_n, tbl[i].right_n, tbl[i].coll_n);
      check($sformatf("vec%0d", i), tbl[i].pos, tbl[i].shift, tbl[i].clear_n,
            tbl[i].load0_n, tbl[i].crash);
    end

    // Right held from lane 3: moves at the first cycle, after HOLD_DELAY,
    // then every REPEAT_PERIOD; saturates (or wraps) at the right edge.
    exp_pos = 3;
    for (int k = 0; k < 15; k++) begin
      tick(0, 1, 1, 0, 1);
      mv     = (k == 0) || (k >= HOLD_DELAY && ((k - HOLD_DELAY) % REPEAT_PERIOD) == 0);
      exp_sh = 2'b11;
      if (mv) begin
        if (exp_pos < NUM_POS - 1) begin
          exp_pos++;
          exp_sh = 2'b10;
        end else if (WRAP) begin
          exp_pos = 0;
          exp_sh  = 2'b10;
        end
      end
      check($sformatf("repeat%0d", k), exp_pos, exp_sh, 1, 1, 0);
    end
    tick(0, 1, 1, 1, 1);
    check("repeat_release", exp_pos, 2'b11, 1, 1, 0);
    tick(0, 1, 1, 1, 1);
    tick(0, 0, 1, 1, 1);
    check("restart_clear", 3, 2'b11, 0, 1, 0);
    tick(0, 1, 1, 1, 1);
    tick(0, 1, 1, 1, 1);
    check("restart_idle", 3, 2'b11, 1, 1, 0);

    // Collision while holding right: frozen for CRASH_CYCLES, reload, and
    // the still-held button does nothing until released and pressed again.
    tick(0, 1, 1, 0, 1);
    check("crash_move", 4, 2'b10, 1, 1, 0);
    tick(0, 1, 1, 0, 1);
    tick(0, 1, 1, 0, 0);
    check("crash_enter", 4, 2'b11, 1, 1, 1);
    for (int k = 1; k < CRASH_CYCLES; k++) begin
      tick(0, 1, 1, 0, 1);
      check($sformatf("crash_hold%0d", k), 4, 2'b11, 1, 1, 1);
    end
    tick(0, 1, 1, 0, 1);
    check("crash_reload", 3, 2'b11, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      tick(0, 1, 1, 0, 1);
      check($sformatf("crash_nomove%0d", k), 3, 2'b11, 1, 1, 0);
    end
    tick(0, 1, 1, 1, 1);
    tick(0, 1, 1, 0, 1);
    check("crash_repress", 4, 2'b10, 1, 1, 0);
    tick(0, 1, 1, 1, 1);
    tick(0, 1, 1, 1, 1);

    // Reset in the middle of a crash window wins immediately.
    tick(0, 1, 1, 1, 0);
    check("rstcrash_enter", 4, 2'b11, 1, 1, 1);
    tick(0, 1, 1, 1, 1);
    tick(1, 1, 1, 1, 1);
    check("rstcrash_reset", 3, 2'b11, 1, 1, 0);
    tick(0, 1, 1, 1, 1);
    tick(0, 1, 1, 1, 1);
    tick(0, 1, 0, 1, 1);
    check("rstcrash_move", 2, 2'b01, 1, 1, 0);

    // Randomized buttons with persistent presses, rare collisions/resets.
    for (int n = 0; n < 3000; n++) begin
      bit r, s, l, rt, c;
      r  = ($urandom_range(0, 299) == 0);
      s  = ($urandom_range(0, 9) == 0) ? !start_n : start_n;
      l  = ($urandom_range(0, 5) == 0) ? !left_n : left_n;
      rt = ($urandom_range(0, 5) == 0) ? !right_n : right_n;
      c  = ($urandom_range(0, 39) != 0);
      tick(r, s, l, rt, c);
      check($sformatf("rand%0d", n), e_pos, e_shift, e_clear, e_load0, e_crash);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
